// File: rtl/cpu0_bus_pkg.sv
// Shared types for the cpu0 memory bus: size codes, arbiter states, request payload.
package cpu0_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned AEXT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_INT16 = 2'd1,
      SZ_INT24 = 2'd2,
      SZ_INT32 = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic              rw;
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

   // Number of bytes touched by an access of the given size code.
   function automatic logic [2:0] nbytes(input logic [SIZE_W-1:0] size);
      return 3'(size) + 3'd1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the two-port memory bus arbiter.
interface mem_bus_arbiter_if;
   import cpu0_bus_pkg::*;

   logic              r0_req;
   logic              r0_rw;
   logic [SIZE_W-1:0] r0_size;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ack;
   logic              r0_err;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_rw;
   logic [SIZE_W-1:0] r1_size;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ack;
   logic              r1_err;
   logic [DATA_W-1:0] r1_rdata;

   logic              m_en;
   logic              m_rw;
   logic [SIZE_W-1:0] m_size;
   logic [ADDR_W-1:0] m_abus;
   logic [DATA_W-1:0] m_dout;
   logic [DATA_W-1:0] m_din;

   // Arbiter side
   modport slave (
      input  r0_req, r0_rw, r0_size, r0_addr, r0_wdata,
      input  r1_req, r1_rw, r1_size, r1_addr, r1_wdata,
      input  m_din,
      output r0_ack, r0_err, r0_rdata,
      output r1_ack, r1_err, r1_rdata,
      output m_en, m_rw, m_size, m_abus, m_dout
   );

   // Requesters and memory side
   modport master (
      output r0_req, r0_rw, r0_size, r0_addr, r0_wdata,
      output r1_req, r1_rw, r1_size, r1_addr, r1_wdata,
      output m_din,
      input  r0_ack, r0_err, r0_rdata,
      input  r1_ack, r1_err, r1_rdata,
      input  m_en, m_rw, m_size, m_abus, m_dout
   );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: on contention the port that did not win last time wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid_c,
   output logic       grant_c
);

   assign valid_c = |req;
   assign grant_c = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between two req/ack requesters with round-robin fairness,
// fixed-length memory cycles and an address-range check.
module mem_bus_arbiter
   import cpu0_bus_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_MAX    = 1023
) (
   input  logic               clock,
   input  logic               reset,
   mem_bus_arbiter_if.slave   bus,
   output logic               busy,
   output logic               grant_id
);

   arb_state_e               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   bus_req_t                 m_q, m_d;
   logic                     m_en_q, m_en_d;
   logic                     gid_d;
   logic                     busy_d;
   logic                     err_lat_q, err_lat_d;
   logic [1:0]               ack_q, ack_d;
   logic [1:0]               err_q, err_d;
   logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;

   bus_req_t                 req0, req1, sel;
   logic                     pick_valid_c, pick_grant_c;
   logic [AEXT_W-1:0]        end_addr;
   logic                     in_range;

   assign req0 = '{rw: bus.r0_rw, size: bus.r0_size, addr: bus.r0_addr, wdata: bus.r0_wdata};
   assign req1 = '{rw: bus.r1_rw, size: bus.r1_size, addr: bus.r1_addr, wdata: bus.r1_wdata};

   rr_pick2 u_pick (
      .req     ({bus.r1_req, bus.r0_req}),
      .last    (grant_id),
      .valid_c (pick_valid_c),
      .grant_c (pick_grant_c)
   );

   assign sel = pick_grant_c ? req1 : req0;

   // Last byte touched, computed one bit wider so a top-of-space address cannot wrap into range.
   assign end_addr = {1'b0, sel.addr} + AEXT_W'(nbytes(sel.size)) - AEXT_W'(1);
   assign in_range = (end_addr <= AEXT_W'(ADDR_MAX));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      m_d       = m_q;
      m_en_d    = m_en_q;
      gid_d     = grant_id;
      err_lat_d = err_lat_q;
      ack_d     = 2'b00;
      err_d     = 2'b00;
      rdata_d   = rdata_q;

      case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               gid_d = pick_grant_c;
               if (in_range) begin
                  m_d       = sel;
                  m_en_d    = 1'b1;
                  cnt_d     = CNT_W'(WAIT_CYCLES - 1);
                  err_lat_d = 1'b0;
                  state_d   = ACCESS;
               end else begin
                  err_lat_d              = 1'b1;
                  rdata_d[pick_grant_c]  = '0;
                  state_d                = RESP;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rdata_d[grant_id] = m_q.rw ? bus.m_din : '0;
               m_en_d            = 1'b0;
               state_d           = RESP;
            end
         end
         RESP: begin
            ack_d[grant_id] = 1'b1;
            err_d[grant_id] = err_lat_q;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         m_q       <= '{rw: 1'b1, size: SZ_INT32, addr: '0, wdata: '0};
         m_en_q    <= 1'b0;
         grant_id  <= 1'b1;
         busy      <= 1'b0;
         err_lat_q <= 1'b0;
         ack_q     <= 2'b00;
         err_q     <= 2'b00;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         m_q       <= m_d;
         m_en_q    <= m_en_d;
         grant_id  <= gid_d;
         busy      <= busy_d;
         err_lat_q <= err_lat_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.m_en     = m_en_q;
   assign bus.m_rw     = m_q.rw;
   assign bus.m_size   = m_q.size;
   assign bus.m_abus   = m_q.addr;
   assign bus.m_dout   = m_q.wdata;
   assign bus.r0_ack   = ack_q[0];
   assign bus.r1_ack   = ack_q[1];
   assign bus.r0_err   = err_q[0];
   assign bus.r1_err   = err_q[1];
   assign bus.r0_rdata = rdata_q[0];
   assign bus.r1_rdata = rdata_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with WAIT_CYCLES=1 on a byte memory,
// one with WAIT_CYCLES=3 on an address-echo memory.
module tb_mem_bus_arbiter;
   import cpu0_bus_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_bus_arbiter_if ba ();
   mem_bus_arbiter_if bb ();
   logic busy_a, gid_a, busy_b, gid_b;

   mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_MAX(1023)) dut_a (
      .clock(clock), .reset(reset), .bus(ba.slave), .busy(busy_a), .grant_id(gid_a)
   );
   mem_bus_arbiter #(.WAIT_CYCLES(3), .ADDR_MAX(1023)) dut_b (
      .clock(clock), .reset(reset), .bus(bb.slave), .busy(busy_b), .grant_id(gid_b)
   );

   // Little-endian byte memory for dut_a; sub-word reads are zero-extended.
   logic [7:0] mem [0:1023];
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[10'(i)] = 8'(i * 3 + 1);
         mem[16] = 8'h04; mem[17] = 8'h00; mem[18] = 8'hA0; mem[19] = 8'h08;
         mem[1023] = 8'hA5;
      end else if (ba.m_en && !ba.m_rw) begin
         mem[ba.m_abus[9:0]] = ba.m_dout[7:0];
         if (ba.m_size >= 2'd1) mem[ba.m_abus[9:0] + 10'd1] = ba.m_dout[15:8];
         if (ba.m_size >= 2'd2) mem[ba.m_abus[9:0] + 10'd2] = ba.m_dout[23:16];
         if (ba.m_size == 2'd3) mem[ba.m_abus[9:0] + 10'd3] = ba.m_dout[31:24];
      end
   end

   always_comb begin
      ba.m_din       = '0;
      ba.m_din[7:0]  = mem[ba.m_abus[9:0]];
      if (ba.m_size >= 2'd1) ba.m_din[15:8]  = mem[ba.m_abus[9:0] + 10'd1];
      if (ba.m_size >= 2'd2) ba.m_din[23:16] = mem[ba.m_abus[9:0] + 10'd2];
      if (ba.m_size == 2'd3) ba.m_din[31:24] = mem[ba.m_abus[9:0] + 10'd3];
   end

   assign bb.m_din = {16'h1234, bb.m_abus[15:0]};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic get_ack(input bit d, input bit p);
      case ({d, p})
         2'b00:   return ba.r0_ack;
         2'b01:   return ba.r1_ack;
         2'b10:   return bb.r0_ack;
         default: return bb.r1_ack;
      endcase
   endfunction

   function automatic logic get_err(input bit d, input bit p);
      case ({d, p})
         2'b00:   return ba.r0_err;
         2'b01:   return ba.r1_err;
         2'b10:   return bb.r0_err;
         default: return bb.r1_err;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input bit d, input bit p);
      case ({d, p})
         2'b00:   return ba.r0_rdata;
         2'b01:   return ba.r1_rdata;
         2'b10:   return bb.r0_rdata;
         default: return bb.r1_rdata;
      endcase
   endfunction

   task automatic drive(input bit d, input bit p, input logic req, input logic rw,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      case ({d, p})
         2'b00: begin ba.r0_req = req; ba.r0_rw = rw; ba.r0_size = sz; ba.r0_addr = a; ba.r0_wdata = wd; end
         2'b01: begin ba.r1_req = req; ba.r1_rw = rw; ba.r1_size = sz; ba.r1_addr = a; ba.r1_wdata = wd; end
         2'b10: begin bb.r0_req = req; bb.r0_rw = rw; bb.r0_size = sz; bb.r0_addr = a; bb.r0_wdata = wd; end
         default: begin bb.r1_req = req; bb.r1_rw = rw; bb.r1_size = sz; bb.r1_addr = a; bb.r1_wdata = wd; end
      endcase
   endtask

   int          lat, en_cyc, abus_bad;
   logic [1:0]  en_size;
   logic        en_rw;
   logic [31:0] rd;
   logic        er;

   // One request from presentation to ack; clocks counted from the edge after presentation.
   task automatic xact(input bit d, input bit p, input logic rw, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
      drive(d, p, 1'b1, rw, sz, a, wd);
      lat = 0; en_cyc = 0; abus_bad = 0; en_size = 2'bxx; en_rw = 1'bx;
      do begin
         @(posedge clock); @(negedge clock);
         lat++;
         if (d ? bb.m_en : ba.m_en) begin
            en_cyc++;
            en_size = d ? bb.m_size : ba.m_size;
            en_rw   = d ? bb.m_rw : ba.m_rw;
            if ((d ? bb.m_abus : ba.m_abus) !== a) abus_bad++;
         end
      end while (!get_ack(d, p) && lat < 20);
      rd = get_rdata(d, p);
      er = get_err(d, p);
      drive(d, p, 1'b0, rw, sz, a, wd);
      @(posedge clock); @(negedge clock);
   endtask

   int order [8];
   int n_ack, cnt0, cnt1, both, cyc;

   initial begin
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) drive(1'(d), 1'(p), 1'b0, 1'b1, 2'd0, '0, '0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_m_en",     32'(ba.m_en),   32'd0);
      check("rst_m_rw",     32'(ba.m_rw),   32'd1);
      check("rst_m_size",   32'(ba.m_size), 32'd3);
      check("rst_m_abus",   ba.m_abus,      32'd0);
      check("rst_grant_id", 32'(gid_a),     32'd1);
      check("rst_busy",     32'(busy_a),    32'd0);
      check("rst_ack",      32'({ba.r1_ack, ba.r0_ack}), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Port 0 INT32 read
      xact(1'b0, 1'b0, 1'b1, 2'd3, 32'h10, 32'h0);
      check("rd32_latency", 32'(lat), 32'd3);
      check("rd32_en_cyc",  32'(en_cyc), 32'd1);
      check("rd32_rdata",   rd, 32'h08A00004);
      check("rd32_err",     32'(er), 32'd0);
      check("rd32_ack_drop", 32'(ba.r0_ack), 32'd0);
      check("rd32_rdata_hold", ba.r0_rdata, 32'h08A00004);
      check("rd32_idle", 32'(busy_a), 32'd0);

      // Port 1 BYTE write, then port 0 BYTE read back
      xact(1'b0, 1'b1, 1'b0, 2'd0, 32'h20, 32'hFFFF_FF5A);
      check("wr8_latency", 32'(lat), 32'd3);
      check("wr8_m_size",  32'(en_size), 32'd0);
      check("wr8_m_rw",    32'(en_rw), 32'd0);
      check("wr8_rdata",   rd, 32'd0);
      check("wr8_grant",   32'(gid_a), 32'd1);
      xact(1'b0, 1'b0, 1'b1, 2'd0, 32'h20, 32'h0);
      check("rb8_rdata",   rd, 32'h0000005A);

      // Range boundaries
      xact(1'b0, 1'b1, 1'b1, 2'd0, 32'd1023, 32'h0);
      check("b1023_err",   32'(er), 32'd0);
      check("b1023_rdata", rd, 32'h000000A5);
      xact(1'b0, 1'b1, 1'b1, 2'd3, 32'd1022, 32'h0);
      check("oor_latency", 32'(lat), 32'd2);
      check("oor_en_cyc",  32'(en_cyc), 32'd0);
      check("oor_err",     32'(er), 32'd1);
      check("oor_rdata",   rd, 32'd0);
      check("oor_err_drop", 32'(ba.r1_err), 32'd0);
      xact(1'b0, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0);
      check("wrap_err",    32'(er), 32'd1);
      check("wrap_en_cyc", 32'(en_cyc), 32'd0);
      xact(1'b0, 1'b0, 1'b1, 2'd1, 32'd1022, 32'h0);
      check("h1022_err",   32'(er), 32'd0);
      check("h1022_rdata", rd, 32'h0000A5FB);

      // Contention straight out of reset, both held continuously
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h10, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h20, 32'h0);
      n_ack = 0; cnt0 = 0; cnt1 = 0; both = 0; cyc = 0;
      while (n_ack < 8 && cyc < 60) begin
         @(posedge clock); @(negedge clock);
         cyc++;
         if (ba.r0_ack && ba.r1_ack) both++;
         if (ba.r0_ack) begin order[n_ack] = 0; n_ack++; cnt0++; end
         else if (ba.r1_ack) begin order[n_ack] = 1; n_ack++; cnt1++; end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h10, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h20, 32'h0);
      check("rr_n_ack", 32'(n_ack), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < n_ack) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
      check("rr_cnt0", 32'(cnt0), 32'd4);
      check("rr_cnt1", 32'(cnt1), 32'd4);
      check("rr_both_ack", 32'(both), 32'd0);
      check("rr_r0_rdata", ba.r0_rdata, 32'h08A00004);
      check("rr_r1_rdata", ba.r1_rdata, 32'h00000061);
      repeat (2) @(negedge clock);

      // WAIT_CYCLES = 3 read
      xact(1'b1, 1'b0, 1'b1, 2'd3, 32'h44, 32'h0);
      check("w3_latency",  32'(lat), 32'd5);
      check("w3_en_cyc",   32'(en_cyc), 32'd3);
      check("w3_abus_bad", 32'(abus_bad), 32'd0);
      check("w3_rdata",    rd, 32'h12340044);

      // Reset in the middle of a write access
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 32'h40, 32'hDEADBEEF);
      @(posedge clock); @(negedge clock);
      check("mid_m_en", 32'(bb.m_en), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_m_en", 32'(bb.m_en), 32'd0);
      check("async_busy", 32'(busy_b), 32'd0);
      check("async_rdata", bb.r0_rdata, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h40, 32'hDEADBEEF);
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      both = 0;
      repeat (4) begin
         @(posedge clock); @(negedge clock);
         if (bb.r0_ack || bb.r1_ack) both++;
      end
      check("abort_no_ack", 32'(both), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 32'h50, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 32'h60, 32'h0);
      cyc = 0;
      do begin
         @(posedge clock); @(negedge clock);
         cyc++;
      end while (!bb.r0_ack && !bb.r1_ack && cyc < 20);
      check("post_rst_ack0", 32'(bb.r0_ack), 32'd1);
      check("post_rst_ack1", 32'(bb.r1_ack), 32'd0);
      check("post_rst_lat",  32'(cyc), 32'd5);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'h50, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 32'h60, 32'h0);
      repeat (8) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
